// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared definitions for the ram_ctrl slice.
//   state_t         controller FSM states (INIT fill, IDLE, WAIT states, RESP)
//   WAIT_CYC_MAX    largest supported number of access wait states
//   WAIT_CNT_W      width of the wait-state counter
//   f_even_parity   even-parity bit over the low i_width bits of i_data
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam int unsigned WAIT_CYC_MAX = 15;
  localparam int unsigned WAIT_CNT_W   = $clog2(WAIT_CYC_MAX + 1);
  localparam int unsigned PARITY_MAX_W = 64;

  // Width is a run-time argument so one function serves any DATA_W up to 64.
  function automatic logic f_even_parity(input logic [PARITY_MAX_W-1:0] i_data,
                                         input int unsigned             i_width);
    logic p;
    p = 1'b0;
    for (int unsigned i = 0; i < PARITY_MAX_W; i++) begin
      if (i < i_width) p = p ^ i_data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/ram_array.sv
// ram_array: word-addressed storage, 2**ADDR_W words of DATA_W bits.
//   clk      write clock
//   i_we     write enable (synchronous write on rising clk)
//   i_waddr  write address
//   i_wdata  write word
//   i_raddr  read address
//   o_rdata  read word (combinational read of i_raddr)
// Contents are not reset; the controller fills them after reset.
module ram_array #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ram_ctrl.sv
// ram_ctrl: single-port RAM controller with post-reset memory fill.
//   clk    clock, all state changes on the rising edge
//   reset  asynchronous active-low reset
//   req    access request, sampled only while ready=1
//   we     1=write, 0=read, qualified by req
//   addr   word address
//   wdata  write data
//   ready  controller accepts a request this cycle (IDLE)
//   done   one-cycle completion pulse for reads and writes
//   rdata  read data, valid with done on a read, held otherwise
//   busy   memory fill (INIT) in progress
//   perr   (RAM_CTRL_PARITY_EN only) stored parity mismatch, with done on a read
// Optional feature macro: RAM_CTRL_PARITY_EN adds a stored even-parity bit per
// word and the perr output.
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 7,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       WAIT_CYC = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
`ifdef RAM_CTRL_PARITY_EN
  ,
  output logic              perr
`endif
);

  if (WAIT_CYC > WAIT_CYC_MAX) begin : g_wait_range
    $error("ram_ctrl: WAIT_CYC above supported maximum");
  end

`ifdef RAM_CTRL_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned WORD_W = DATA_W + PAR_W;

  localparam logic [ADDR_W-1:0]     LAST_ADDR = '1;
  localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
    (WAIT_CYC == 0) ? '0 : WAIT_CNT_W'(WAIT_CYC - 1);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_W-1:0]     r_init_cnt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;

  logic                  w_acc_we;
  logic [ADDR_W-1:0]     w_acc_addr;
  logic [DATA_W-1:0]     w_acc_wdata;
  logic                  w_enter_resp;
  logic                  w_mem_we;
  logic [ADDR_W-1:0]     w_mem_waddr;
  logic [DATA_W-1:0]     w_mem_wdata;
  logic [WORD_W-1:0]     w_mem_wword;
  logic [WORD_W-1:0]     w_mem_rword;
  logic [DATA_W-1:0]     w_rd_data;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_INIT;
    else        r_state <= w_next;
  end

  // Next state and status outputs
  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    done   = 1'b0;
    busy   = 1'b0;
    case (r_state)
      ST_INIT: begin
        busy = 1'b1;
        if (r_init_cnt == LAST_ADDR) w_next = ST_IDLE;
      end
      ST_IDLE: begin
        ready = 1'b1;
        if (req) w_next = (WAIT_CYC == 0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (r_wait_cnt == '0) w_next = ST_RESP;
      end
      ST_RESP: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_INIT;
    endcase
  end

  // With WAIT_CYC=0 RESP is entered on the accepting edge itself, so the
  // access must come straight from the inputs while IDLE; afterwards it comes
  // from the latches, which keeps later input changes out of the access.
  always_comb begin
    w_acc_we    = r_we;
    w_acc_addr  = r_addr;
    w_acc_wdata = r_wdata;
    if (r_state == ST_IDLE) begin
      w_acc_we    = we;
      w_acc_addr  = addr;
      w_acc_wdata = wdata;
    end
    w_enter_resp = (w_next == ST_RESP) && (r_state != ST_RESP);

    w_mem_we    = 1'b0;
    w_mem_waddr = w_acc_addr;
    w_mem_wdata = w_acc_wdata;
    if (r_state == ST_INIT) begin
      w_mem_we    = 1'b1;
      w_mem_waddr = r_init_cnt;
      w_mem_wdata = INIT_VAL;
    end else if (w_enter_resp && w_acc_we) begin
      w_mem_we = 1'b1;
    end
  end

`ifdef RAM_CTRL_PARITY_EN
  assign w_mem_wword = {f_even_parity(PARITY_MAX_W'(w_mem_wdata), DATA_W), w_mem_wdata};
`else
  assign w_mem_wword = w_mem_wdata;
`endif
  assign w_rd_data = w_mem_rword[DATA_W-1:0];

  // Counters, request latches and read data register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_init_cnt <= '0;
      r_wait_cnt <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      // Counter parks on the last address instead of wrapping.
      if ((r_state == ST_INIT) && (r_init_cnt != LAST_ADDR))
        r_init_cnt <= r_init_cnt + ADDR_W'(1);
      if ((r_state == ST_IDLE) && req) begin
        r_we       <= we;
        r_addr     <= addr;
        r_wdata    <= wdata;
        r_wait_cnt <= WAIT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - WAIT_CNT_W'(1);
      end
      if (w_enter_resp && !w_acc_we) r_rdata <= w_rd_data;
    end
  end

  assign rdata = r_rdata;

`ifdef RAM_CTRL_PARITY_EN
  logic r_perr;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_perr <= 1'b0;
    else        r_perr <= w_enter_resp && !w_acc_we &&
                          (f_even_parity(PARITY_MAX_W'(w_rd_data), DATA_W) != w_mem_rword[DATA_W]);
  end
  assign perr = r_perr;
`endif

  ram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (w_mem_waddr),
    .i_wdata (w_mem_wword),
    .i_raddr (w_acc_addr),
    .o_rdata (w_mem_rword)
  );

endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: self-checking bench for ram_ctrl.
// dut  : default parameters (ADDR_W=7, DATA_W=16, WAIT_CYC=1, INIT_VAL=0)
// dut0 : ADDR_W=4, WAIT_CYC=0, INIT_VAL=16'hA5A5 (back-to-back accesses)
module tb_ram_ctrl;

  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 16;
  localparam int unsigned WC    = 1;
  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW0   = 4;
  localparam logic [DW-1:0] INIT0 = 16'hA5A5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          req = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          ready, done, busy;
  logic [DW-1:0] rdata;

  logic           req0 = 1'b0, we0 = 1'b0;
  logic [AW0-1:0] addr0 = '0;
  logic [DW-1:0]  wdata0 = '0;
  logic           ready0, done0, busy0;
  logic [DW-1:0]  rdata0;
`ifdef RAM_CTRL_PARITY_EN
  logic perr, perr0;
`endif

  ram_ctrl #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(WC), .INIT_VAL(16'h0000)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .done(done), .rdata(rdata), .busy(busy)
`ifdef RAM_CTRL_PARITY_EN
    , .perr(perr)
`endif
  );

  ram_ctrl #(.ADDR_W(AW0), .DATA_W(DW), .WAIT_CYC(0), .INIT_VAL(INIT0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .ready(ready0), .done(done0), .rdata(rdata0), .busy(busy0)
`ifdef RAM_CTRL_PARITY_EN
    , .perr(perr0)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] model  [DEPTH];
  logic [DW-1:0] model0 [16];

  typedef struct {
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int i = 0; i < 16; i++) model0[i] = INIT0;
  endtask

  // Run through INIT with a write request held high the whole time; it must
  // be ignored and no done may appear.
  task automatic wait_init(input string tag);
    int n, dn;
    n = 0; dn = 0;
    req = 1'b1; we = 1'b1; addr = AW'(10); wdata = 16'h5555;
    while (busy === 1'b1 && n < 400) begin
      if (done === 1'b1) dn++;
      n++;
      step();
    end
    req = 1'b0;
    chk({tag, "_busy_cycles"}, n, 128);
    chk({tag, "_ready_after"}, ready, 1);
    chk({tag, "_done_in_init"}, dn, 0);
  endtask

  // One access on dut with random noise on the inputs while in flight.
  task automatic access(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input string tag, output logic [DW-1:0] rd, output logic pe);
    int n;
    logic [DW-1:0] held;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin step(); n++; end
    chk({tag, "_ready"}, ready, 1);
    req = 1'b1; we = w; addr = a; wdata = d;
    step();
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      req = 1'($urandom); we = 1'($urandom); addr = AW'($urandom); wdata = DW'($urandom);
      step();
      n++;
    end
    req = 1'b0;
    chk({tag, "_latency"}, n, WC);
    rd = rdata;
`ifdef RAM_CTRL_PARITY_EN
    pe = perr;
`else
    pe = 1'b0;
`endif
    held = rdata;
    if (w) model[a] = d;
    step();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_rdata_hold"}, rdata, held);
  endtask

  logic [DW-1:0] rd;
  logic          pe;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{w:1'b0, a:7'd0,   d:16'h0000, exp:16'h0000};
    tbl[1]  = '{w:1'b0, a:7'd64,  d:16'h0000, exp:16'h0000};
    tbl[2]  = '{w:1'b0, a:7'd127, d:16'h0000, exp:16'h0000};
    tbl[3]  = '{w:1'b0, a:7'd10,  d:16'h0000, exp:16'h0000};
    tbl[4]  = '{w:1'b1, a:7'd5,   d:16'hBEEF, exp:16'h0000};
    tbl[5]  = '{w:1'b0, a:7'd5,   d:16'h0000, exp:16'hBEEF};
    tbl[6]  = '{w:1'b1, a:7'd127, d:16'hFFFF, exp:16'h0000};
    tbl[7]  = '{w:1'b0, a:7'd127, d:16'h0000, exp:16'hFFFF};
    tbl[8]  = '{w:1'b0, a:7'd126, d:16'h0000, exp:16'h0000};
    tbl[9]  = '{w:1'b1, a:7'd0,   d:16'h0001, exp:16'h0000};
    tbl[10] = '{w:1'b0, a:7'd0,   d:16'h0000, exp:16'h0001};
    tbl[11] = '{w:1'b0, a:7'd5,   d:16'h0000, exp:16'hBEEF};

    // Reset state
    reset = 1'b0;
    model_reset();
    step(); step();
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 1);
    chk("rst_rdata", rdata, 0);
    chk("rst0_busy", busy0, 1);
    reset = 1'b1;
    wait_init("init1");

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      access(tbl[i].w, tbl[i].a, tbl[i].d, $sformatf("tbl%0d", i), rd, pe);
      if (!tbl[i].w) chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp);
    end

    // Randomized accesses against the array model
    for (int i = 0; i < 150; i++) begin
      logic          w;
      logic [AW-1:0] a;
      logic [DW-1:0] d, e;
      w = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
      d = DW'($urandom);
      e = model[a];
      access(w, a, d, $sformatf("rnd%0d", i), rd, pe);
      if (!w) chk($sformatf("rnd%0d_rdata", i), rd, e);
`ifdef RAM_CTRL_PARITY_EN
      chk($sformatf("rnd%0d_perr", i), pe, 0);
`endif
    end

    // Request during WAIT is dropped
    access(1'b1, 7'd21, 16'h0BAD, "w41a", rd, pe);
    while (ready !== 1'b1) step();
    req = 1'b1; we = 1'b1; addr = 7'd20; wdata = 16'h1111;
    step();
    req = 1'b1; we = 1'b1; addr = 7'd21; wdata = 16'h2222;
    step();
    req = 1'b0;
    model[20] = 16'h1111;
    chk("w41_done", done, 1);
    begin
      int dn;
      dn = 0;
      for (int i = 0; i < 5; i++) begin step(); if (done === 1'b1) dn++; end
      chk("w41_no_extra_done", dn, 0);
    end
    access(1'b0, 7'd21, 16'h0, "w41b", rd, pe);
    chk("w41_addr21", rd, 16'h0BAD);
    access(1'b0, 7'd20, 16'h0, "w41c", rd, pe);
    chk("w41_addr20", rd, 16'h1111);

    // Back-to-back on dut0 (WAIT_CYC=0): writes then reads with req held
    for (int s = 0; s < 16; s++) begin
      chk($sformatf("b2b_w%0d_ready", s), ready0, (s % 2 == 0) ? 1 : 0);
      chk($sformatf("b2b_w%0d_done", s), done0, (s % 2 == 1) ? 1 : 0);
      req0 = 1'b1; we0 = 1'b1;
      if (s % 2 == 0) begin
        addr0 = AW0'(s / 2); wdata0 = 16'h0100 + DW'(s / 2);
        model0[s / 2] = 16'h0100 + DW'(s / 2);
      end else begin
        addr0 = AW0'($urandom); wdata0 = DW'($urandom);
      end
      step();
    end
    begin
      logic [AW0-1:0] prev;
      prev = '0;
      for (int s = 0; s < 32; s++) begin
        chk($sformatf("b2b_r%0d_ready", s), ready0, (s % 2 == 0) ? 1 : 0);
        chk($sformatf("b2b_r%0d_done", s), done0, (s % 2 == 1) ? 1 : 0);
        if (s % 2 == 1) chk($sformatf("b2b_r%0d_rdata", s), rdata0, model0[prev]);
        req0 = 1'b1; we0 = 1'b0;
        if (s % 2 == 0) begin
          addr0 = AW0'(s / 2); prev = addr0;
        end else begin
          addr0 = AW0'($urandom); we0 = 1'($urandom); wdata0 = DW'($urandom);
        end
        step();
      end
    end
    req0 = 1'b0;

    // Reset during WAIT aborts a pending write; INIT restarts
    access(1'b1, 7'd9, 16'h7777, "r42a", rd, pe);
    access(1'b0, 7'd9, 16'h0, "r42b", rd, pe);
    chk("r42_pre", rd, 16'h7777);
    while (ready !== 1'b1) step();
    req = 1'b1; we = 1'b1; addr = 7'd9; wdata = 16'h1234;
    step();
    req = 1'b0;
    reset = 1'b0;
    #1;
    chk("r42_rst_ready", ready, 0);
    chk("r42_rst_done", done, 0);
    chk("r42_rst_busy", busy, 1);
    chk("r42_rst_rdata", rdata, 0);
    step(); step();
    reset = 1'b1;
    model_reset();
    wait_init("init2");
    access(1'b0, 7'd9, 16'h0, "r42c", rd, pe);
    chk("r42_addr9", rd, 16'h0000);
    access(1'b0, 7'd5, 16'h0, "r42d", rd, pe);
    chk("r42_addr5", rd, 16'h0000);

`ifdef RAM_CTRL_PARITY_EN
    // Corrupt one stored bit and read it back
    dut.u_array.r_mem[3][0] = ~dut.u_array.r_mem[3][0];
    access(1'b0, 7'd3, 16'h0, "par_a", rd, pe);
    chk("par_bad_perr", pe, 1);
    access(1'b0, 7'd4, 16'h0, "par_b", rd, pe);
    chk("par_clean_perr", pe, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, address width; depth is 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 16, word width.
REQ-003 SHALL have parameter WAIT_CYC, default 1, access wait states; legal range 0..15.
REQ-004 SHALL have parameter INIT_VAL, default 0, DATA_W-wide fill value written after reset.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port req, input, 1, access request; sampled only while ready=1.
REQ-008 SHALL have port we, input, 1, 1=write, 0=read; qualified by req.
REQ-009 SHALL have port addr, input, ADDR_W, word address.
REQ-010 SHALL have port wdata, input, DATA_W, write data.
REQ-011 SHALL have port ready, output, 1, controller accepts a request this cycle.
REQ-012 SHALL have port done, output, 1, one-cycle completion pulse for reads and writes.
REQ-013 SHALL have port rdata, output, DATA_W, read data; valid only when done=1 for a read.
REQ-014 SHALL have port busy, output, 1, memory fill in progress.

Function
REQ-015 SHALL implement the states INIT, IDLE, WAIT and RESP.
REQ-016 INIT SHALL write INIT_VAL to one address per cycle, from 0 to 2**ADDR_W-1, then enter IDLE; INIT lasts exactly 2**ADDR_W cycles, with busy=1 and ready=0.
REQ-017 IDLE SHALL drive ready=1; req=1 at edge T latches we, addr and wdata and leaves IDLE.
REQ-018 After acceptance, the controller SHALL enter WAIT for WAIT_CYC cycles, or go directly to RESP when WAIT_CYC=0.
REQ-019 RESP SHALL last one cycle with done=1, then return to IDLE.
REQ-020 Latency: done SHALL be high in cycle T+1+WAIT_CYC; the minimum request spacing is WAIT_CYC+2 cycles.
REQ-021 A write SHALL commit to the array on entry to RESP.
REQ-022 A read SHALL present the word at the latched address on rdata during RESP.
REQ-023 A read issued after a completed write to the same address SHALL return the new data.
REQ-024 req while ready=0 SHALL be ignored, with no queueing.
REQ-025 Input changes after acceptance SHALL not affect the access in flight.
REQ-026 The INIT address counter SHALL not wrap back to 0; the exit condition is the last address.
REQ-027 rdata SHALL hold its last value outside RESP.

Reset
REQ-028 While reset=0: ready=0, done=0, busy=1, rdata=0, state=INIT, INIT counter=0.
REQ-029 Reset asserted mid-access SHALL abort the access; a pending write is not committed.
REQ-030 After reset is released, INIT SHALL restart from address 0.
REQ-031 Array contents need no reset except through INIT.

Configuration
REQ-032 Macro RAM_CTRL_PARITY_EN defined: each word SHALL store an extra even-parity bit, written on INIT and on writes.
REQ-033 With RAM_CTRL_PARITY_EN defined, output perr SHALL assert with done on a read whose stored parity mismatches; perr=0 at reset.
REQ-034 Macro RAM_CTRL_PARITY_EN undefined: there SHALL be no perr port and no parity storage.

Structure
REQ-035 Package ram_ctrl_pkg SHALL hold the state enumeration, the WAIT_CYC maximum constant (15) and a parity function parameterised on width.
REQ-036 Sub-module ram_array SHALL hold the storage, with parameters ADDR_W and DATA_W (plus 1 for the parity bit when enabled), one synchronous write port and one read port.
REQ-037 ram_ctrl SHALL contain the FSM, wait counter, INIT counter and request latches.

Verification
REQ-038 Default parameters, release reset at cycle 0 -> busy=1 for 128 cycles, ready rises at cycle 128, then reads of addresses 0, 64 and 127 return 0.
REQ-039 WAIT_CYC=1: write 0xBEEF to addr 5 accepted at T -> done at T+2; read of addr 5 accepted at T+3 -> done at T+5 with rdata=0xBEEF.
REQ-040 WAIT_CYC=0: back-to-back read requests held high -> ready high every second cycle, done at T+1 for each access.
REQ-041 req pulsed while busy=1 or during WAIT -> no done pulse and memory unchanged.
REQ-042 Write 0x1234 to addr 9, reset pulled low in WAIT -> after the new INIT, a read of addr 9 returns INIT_VAL.
REQ-043 With RAM_CTRL_PARITY_EN defined, force-flip one stored bit of addr 3 and read it -> perr=1 with done; a clean read of another address gives perr=0.
